instr_fetch_unit: RTL and testbench

- Instruction-side counterpart of the ALU datapath. The ALU consumes a 32-bit instruction code; this block produces it.
- Walks the program counter through the Harvard instruction memory and prefetches words into a small queue.
- Presents each instruction to the ALU/decode stage over a valid/ready handshake.
- Resolves JMP and HALT locally; neither opcode is ever issued downstream.

---
 rtl/harvard_pkg.sv | 40 ++++
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/fetch_fifo.sv | 44 ++++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/harvard_pkg.sv
// Shared definitions for the Harvard instruction side: opcode map,
// opcode field position, fetch FSM states and response classification.
package harvard_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  // MOV .. LRSH (including LOAD/STORE) occupy the contiguous range 0..16.
  localparam logic [OPC_W-1:0] OP_MOVI = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LRSH = 6'b010000;
  localparam logic [OPC_W-1:0] OP_JMP  = 6'b010001;
  localparam logic [OPC_W-1:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    RESP_PUSH    = 2'd0,
    RESP_JMP     = 2'd1,
    RESP_HALT    = 2'd2,
    RESP_ILLEGAL = 2'd3
  } resp_kind_t;

  // What the fetch unit does with a returned word, keyed on its opcode.
  function automatic resp_kind_t classify(input logic [OPC_W-1:0] opc);
    resp_kind_t kind;
    if (opc <= OP_LRSH)      kind = RESP_PUSH;
    else if (opc == OP_JMP)  kind = RESP_JMP;
    else if (opc == OP_HALT) kind = RESP_HALT;
    else                     kind = RESP_ILLEGAL;
    return kind;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port plus the code handshake toward decode.
//
// Handshake: code/code_valid come from the producer (master). A word moves
// on any cycle with code_valid & code_ready. While code_valid=1 and
// code_ready=0 the producer keeps code unchanged and code_valid high.
// code_ready may depend on nothing but the consumer's own state.
// Memory: imem_rdata answers the imem_en/imem_addr of the previous cycle.
interface instr_fetch_unit_if
  import harvard_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] code;
  logic               code_valid;
  logic               code_ready;

  modport master (
    output imem_en, imem_addr, code, code_valid,
    input  imem_rdata, code_ready
  );

  modport slave (
    input  imem_en, imem_addr, code, code_valid,
    output imem_rdata, code_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding prefetched instruction words.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointer and occupancy bookkeeping; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Data storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= din;
  end

  assign dout  = store[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: walks pc through instruction memory, prefetches into
// a small queue and hands words to decode. JMP and HALT are consumed here.
module instr_fetch_unit
  import harvard_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  instr_fetch_unit_if.master  bus,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic                illegal,
  output fetch_state_t        state
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_t       state_nxt;
  logic               inflight;    // a request was issued last cycle
  logic               squash;      // ... and its response must be dropped
  logic               req;
  logic               pop;
  logic               push;
  logic               resp_valid;
  logic               is_jmp;
  logic               is_halt;
  logic [OPC_W-1:0]   opc;
  resp_kind_t         kind;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_head;
  logic [CNT_W:0]     occ;
  logic [CNT_W:0]     lim;
  logic               unused_rdata_bits;

  assign unused_rdata_bits = ^bus.imem_rdata[OPC_LSB-1:ADDR_W];

  // Classify this cycle's memory response and derive push/jump/halt/illegal.
  always_comb begin
    opc        = bus.imem_rdata[OPC_MSB:OPC_LSB];
    kind       = classify(opc);
    resp_valid = inflight & ~squash;
    push       = resp_valid & (kind == RESP_PUSH);
    is_jmp     = resp_valid & (kind == RESP_JMP);
    is_halt    = resp_valid & (kind == RESP_HALT);
    illegal    = resp_valid & (kind == RESP_ILLEGAL);
  end

  // Issue a read only if the queue can absorb it even when nobody pops;
  // a pop this cycle frees one slot early, which keeps one word per cycle.
  always_comb begin
    pop = bus.code_valid & bus.code_ready;
    occ = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    lim = DEPTH_L + {{CNT_W{1'b0}}, pop};
    req = (state == ST_RUN) && (occ < lim);
  end

  // pc, outstanding-request and squash tracking. A JMP or HALT response
  // kills the request issued alongside it; older queued words stay.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else begin
      inflight <= req;
      squash   <= req & (is_jmp | is_halt);
      if (is_jmp)   pc <= bus.imem_rdata[ADDR_W-1:0];
      else if (req) pc <= pc + 1'b1;
    end
  end

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; HALTED is left only through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start)      state_nxt = ST_RUN;
      ST_RUN:    if (is_halt)    state_nxt = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  fetch_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.imem_rdata),
    .pop   (pop),
    .dout  (fifo_head),
    .count (count),
    .empty (fifo_empty)
  );

  assign bus.imem_en    = req;
  assign bus.imem_addr  = req ? pc : '0;
  assign bus.code_valid = ~fifo_empty;
  assign bus.code       = fifo_empty ? '0 : fifo_head;
  assign halted         = (state == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance at RESET_PC=0 and one
// at RESET_PC=8'hFE for the wrap case, each with its own memory model.
module tb_instr_fetch_unit;
  import harvard_pkg::*;

  localparam logic [5:0] T_ADD = 6'd2;
  localparam logic [5:0] T_SUB = 6'd3;
  localparam logic [5:0] T_MUL = 6'd4;
  localparam logic [5:0] T_OR  = 6'd6;
  localparam logic [5:0] T_XOR = 6'd7;
  localparam logic [5:0] T_NOT = 6'd8;
  localparam logic [5:0] T_JMP = 6'b010001;
  localparam logic [5:0] T_HLT = 6'b111111;
  localparam logic [5:0] T_BAD = 6'b100000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_w = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(8)) bus ();
  instr_fetch_unit_if #(.ADDR_W(8)) bus_w ();

  logic [7:0]   pc, pc_w;
  logic         halted, halted_w, illegal, illegal_w;
  fetch_state_t state, state_w;

  instr_fetch_unit #(.ADDR_W(8), .FIFO_DEPTH(2), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .pc(pc), .halted(halted), .illegal(illegal), .state(state)
  );

  instr_fetch_unit #(.ADDR_W(8), .FIFO_DEPTH(2), .RESET_PC(8'hFE)) u_wrap (
    .clk(clk), .rst(rst), .start(start_w), .bus(bus_w),
    .pc(pc_w), .halted(halted_w), .illegal(illegal_w), .state(state_w)
  );

  // ---------------- memory models ----------------
  logic [31:0] mem   [256];
  logic [31:0] mem_w [256];

  always @(posedge clk) begin
    if (bus.imem_en)   bus.imem_rdata   <= mem[bus.imem_addr];
    if (bus_w.imem_en) bus_w.imem_rdata <= mem_w[bus_w.imem_addr];
  end

  // ---------------- monitor ----------------
  logic [31:0] got_q[$];
  logic [31:0] got_w_q[$];
  logic [31:0] exp_q[$];
  int          xfer_cyc[$];
  logic [7:0]  addr_q[$];
  int          cyc = 0;
  int          ill_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.code_valid && bus.code_ready) begin
        got_q.push_back(bus.code);
        xfer_cyc.push_back(cyc);
      end
      if (bus.imem_en) addr_q.push_back(bus.imem_addr);
      if (illegal) ill_cnt++;
      if (bus_w.code_valid && bus_w.code_ready) got_w_q.push_back(bus_w.code);
    end
  end

  // ---------------- scoreboard / checking ----------------
  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic check_stream(input string tag, input bit w);
    int n;
    logic [31:0] g;
    n = w ? got_w_q.size() : got_q.size();
    check({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() > 0) begin
        g = w ? got_w_q[i] : got_q[i];
        check($sformatf("%s_word%0d", tag, i), g, exp_q.pop_front());
      end
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [25:0] imm);
    return {opc, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]   = mk(T_HLT, 26'h0);
      mem_w[i] = mk(T_HLT, 26'h0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    start_w = 1'b0;
    bus.code_ready = 1'b0;
    bus_w.code_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    got_q.delete();
    got_w_q.delete();
    xfer_cyc.delete();
    addr_q.delete();
    exp_q.delete();
    ill_cnt = 0;
  endtask

  task automatic pulse_start(input bit w);
    if (w) start_w = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start_w = 1'b0;
  endtask

  task automatic run_to_halt(input bit w, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (w ? halted_w : halted) break;
      tick();
    end
    check({tag, "_halt_reached"}, w ? halted_w : halted, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] code0;
  bit          seen;

  initial begin
    bus.code_ready = 1'b0;
    bus_w.code_ready = 1'b0;
    fill_mem();

    // Reset state
    do_reset();
    check("rst_code_valid", bus.code_valid, 1'b0);
    check("rst_code", bus.code, 32'h0);
    check("rst_imem_en", bus.imem_en, 1'b0);
    check("rst_pc", pc, 8'h00);
    check("rst_halted", halted, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_state", state, ST_IDLE);
    check("rst_pc_wrap", pc_w, 8'hFE);

    // Straight line: four words on consecutive cycles, then halted
    fill_mem();
    mem[0] = mk(T_ADD, 26'h1); mem[1] = mk(T_SUB, 26'h2);
    mem[2] = mk(T_MUL, 26'h3); mem[3] = mk(T_OR,  26'h4);
    for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
    bus.code_ready = 1'b1;
    pulse_start(1'b0);
    run_to_halt(1'b0, 40, "straight");
    check("straight_nxfer", xfer_cyc.size(), 4);
    for (int i = 1; i < xfer_cyc.size(); i++)
      check($sformatf("straight_gap%0d", i), xfer_cyc[i] - xfer_cyc[i-1], 1);
    check_stream("straight", 1'b0);
    check("straight_nreq", addr_q.size(), 6);
    if (addr_q.size() > 0) check("straight_last_addr", addr_q[$], 8'h05);
    check("straight_pc", pc, 8'h06);
    pulse_start(1'b0);
    tick();
    check("halted_ignores_start", state, ST_HALTED);
    check("halted_no_req", bus.imem_en, 1'b0);
    check("halted_still", halted, 1'b1);

    // Backpressure: code held stable, no requests once the queue is full
    do_reset();
    fill_mem();
    for (int i = 0; i < 8; i++) begin
      mem[i] = mk(T_ADD, 26'(16 + i));
      exp_q.push_back(mem[i]);
    end
    bus.code_ready = 1'b1;
    pulse_start(1'b0);
    tick(); tick(); tick();
    bus.code_ready = 1'b0;
    code0 = bus.code;
    check("bp_valid_at_stall", bus.code_valid, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_valid%0d", i), bus.code_valid, 1'b1);
      check($sformatf("bp_stable%0d", i), bus.code, code0);
      check($sformatf("bp_no_req%0d", i), bus.imem_en, 1'b0);
      tick();
    end
    bus.code_ready = 1'b1;
    run_to_halt(1'b0, 60, "bp");
    check_stream("bp", 1'b0);

    // Jump: stream is imem[0], imem[1], NOT; XOR never issued
    do_reset();
    fill_mem();
    mem[0]     = mk(T_ADD, 26'h21);
    mem[1]     = mk(T_SUB, 26'h22);
    mem[2]     = mk(T_JMP, 26'h10);
    mem[3]     = mk(T_XOR, 26'h23);
    mem[8'h10] = mk(T_NOT, 26'h24);
    exp_q.push_back(mem[0]); exp_q.push_back(mem[1]); exp_q.push_back(mem[8'h10]);
    bus.code_ready = 1'b1;
    pulse_start(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.imem_en && bus.imem_addr == 8'h10) begin
        tick();
        check("jmp_pc_after_target", pc, 8'h11);
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("jmp_target_fetched", seen, 1'b1);
    run_to_halt(1'b0, 40, "jmp");
    check_stream("jmp", 1'b0);

    // Illegal opcode: one pulse, word skipped
    do_reset();
    fill_mem();
    mem[0] = mk(T_ADD, 26'h31);
    mem[1] = mk(T_BAD, 26'h32);
    mem[2] = mk(T_SUB, 26'h33);
    exp_q.push_back(mem[0]); exp_q.push_back(mem[2]);
    bus.code_ready = 1'b1;
    pulse_start(1'b0);
    run_to_halt(1'b0, 40, "ill");
    check("ill_pulses", ill_cnt, 1);
    check("ill_low_after", illegal, 1'b0);
    check_stream("ill", 1'b0);

    // Wrap: RESET_PC=FE, pc passes through 0
    do_reset();
    fill_mem();
    mem_w[8'hFE] = mk(T_ADD, 26'h41);
    mem_w[8'hFF] = mk(T_SUB, 26'h42);
    exp_q.push_back(mem_w[8'hFE]); exp_q.push_back(mem_w[8'hFF]);
    bus_w.code_ready = 1'b1;
    pulse_start(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pc_w == 8'h00) seen = 1'b1;
      if (halted_w) break;
      tick();
    end
    check("wrap_pc_hit_zero", seen, 1'b1);
    check("wrap_halted", halted_w, 1'b1);
    check("wrap_pc_final", pc_w, 8'h02);
    check_stream("wrap", 1'b1);

    // Reset mid-run with a full queue and a request in flight
    do_reset();
    fill_mem();
    for (int i = 0; i < 6; i++) mem[i] = mk(T_ADD, 26'(8'h50 + i));
    bus.code_ready = 1'b0;
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("mid_full_valid", bus.code_valid, 1'b1);
    bus.code_ready = 1'b1;
    #1;
    check("mid_req_issued", bus.imem_en, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_code_valid", bus.code_valid, 1'b0);
    check("mid_rst_code", bus.code, 32'h0);
    check("mid_rst_imem_en", bus.imem_en, 1'b0);
    check("mid_rst_halted", halted, 1'b0);
    check("mid_rst_illegal", illegal, 1'b0);
    check("mid_rst_state", state, ST_IDLE);
    check("mid_rst_pc", pc, 8'h00);
    tick();
    check("mid_stale_dropped", bus.code_valid, 1'b0);
    got_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(mem[i]);
    pulse_start(1'b0);
    run_to_halt(1'b0, 40, "restart");
    check_stream("restart", 1'b0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
